// File: rtl/bsg_manycore_io_responder.sv
// Host-side responder for manycore IO requests: scratch registers, host events, response FIFO.
// Define BSG_IO_RESPONDER_CYCLE_CTR_EN to map a free-running 64-bit cycle counter at 'h103.
//
// state    | meaning
// RUN      | normal operation, event stores fire their pulses
// FINISHED | finish seen; event stores are acked silently until reset
module bsg_manycore_io_responder #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int resp_els_p     = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      req_v_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [4:0]                req_reg_id_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  output logic                      resp_v_o,
  input  logic                      resp_ready_i,
  output logic                      resp_type_o,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic [4:0]                resp_reg_id_o,
  output logic [x_cord_width_p-1:0] resp_dst_x_o,
  output logic [y_cord_width_p-1:0] resp_dst_y_o,
  output logic                      print_stat_v_o,
  output logic [data_width_p-1:0]   print_stat_tag_o,
  output logic                      putchar_v_o,
  output logic [7:0]                putchar_o,
  output logic                      finish_o,
  output logic [data_width_p-1:0]   finish_code_o,
  output logic [15:0]               err_cnt_o
);
  localparam int ptr_w_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int cnt_w_lp = $clog2(resp_els_p + 1);
  localparam logic [data_width_p-1:0] bad_data_lp = data_width_p'(32'hDEAD_BEEF);

  typedef enum logic {RUN = 1'b0, FINISHED = 1'b1} state_e;

  typedef struct packed {
    logic                      rtype;
    logic [data_width_p-1:0]   data;
    logic [4:0]                reg_id;
    logic [x_cord_width_p-1:0] dst_x;
    logic [y_cord_width_p-1:0] dst_y;
  } resp_s;

  state_e                       state_r, state_n;
  resp_s                        mem_r [resp_els_p];
  resp_s                        enq_data, head;
  logic [ptr_w_lp-1:0]          wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]          cnt_r, cnt_n;
  logic [7:0][data_width_p-1:0] scratch_r;
  logic                         accept, deq;
  logic                         is_scratch, is_ps, is_fin, is_pc;
  logic                         scratch_we, ps_fire, fin_fire, pc_fire, err;

`ifdef BSG_IO_RESPONDER_CYCLE_CTR_EN
  logic [63:0] ctr_r;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) ctr_r <= '0;
    else            ctr_r <= ctr_r + 64'd1;
  end
`endif

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(resp_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign accept     = req_v_i & req_ready_o;
  assign resp_v_o   = (cnt_r != '0);
  assign deq        = resp_v_o & resp_ready_i;
  assign cnt_n      = cnt_r + cnt_w_lp'(accept) - cnt_w_lp'(deq);
  assign is_scratch = (req_addr_i < addr_width_p'(8));
  assign is_ps      = (req_addr_i == addr_width_p'('h100));
  assign is_fin     = (req_addr_i == addr_width_p'('h101));
  assign is_pc      = (req_addr_i == addr_width_p'('h102));

  always_comb begin
    enq_data        = '0;
    enq_data.reg_id = req_reg_id_i;
    enq_data.dst_x  = req_src_x_i;
    enq_data.dst_y  = req_src_y_i;
    scratch_we      = 1'b0;
    ps_fire         = 1'b0;
    fin_fire        = 1'b0;
    pc_fire         = 1'b0;
    err             = 1'b0;
    state_n         = state_r;
    case (req_op_i)
      2'd0: begin
        enq_data.rtype = 1'b1;
        if (is_scratch) enq_data.data = scratch_r[req_addr_i[2:0]];
`ifdef BSG_IO_RESPONDER_CYCLE_CTR_EN
        else if (req_addr_i == addr_width_p'('h103)) enq_data.data = ctr_r[data_width_p-1:0];
`endif
        else begin
          enq_data.data = bad_data_lp;
          err           = 1'b1;
        end
      end
      2'd1: begin
        // event stores are silently absorbed once finished
        if (is_scratch)  scratch_we = 1'b1;
        else if (is_ps)  ps_fire    = (state_r == RUN);
        else if (is_fin) fin_fire   = (state_r == RUN);
        else if (is_pc)  pc_fire    = (state_r == RUN);
        else             err        = 1'b1;
      end
      default: err = 1'b1;
    endcase
    if (accept && fin_fire) state_n = FINISHED;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= RUN;
    else            state_r <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_r[wr_ptr_r] <= enq_data;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_r         <= '0;
      rd_ptr_r         <= '0;
      cnt_r            <= '0;
      req_ready_o      <= 1'b1;
      scratch_r        <= '0;
      print_stat_v_o   <= 1'b0;
      print_stat_tag_o <= '0;
      putchar_v_o      <= 1'b0;
      putchar_o        <= '0;
      finish_code_o    <= '0;
      err_cnt_o        <= '0;
    end else begin
      if (accept) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq)    rd_ptr_r <= ptr_inc(rd_ptr_r);
      cnt_r          <= cnt_n;
      req_ready_o    <= (cnt_n != cnt_w_lp'(resp_els_p));
      print_stat_v_o <= accept & ps_fire;
      putchar_v_o    <= accept & pc_fire;
      if (accept && scratch_we) scratch_r[req_addr_i[2:0]] <= req_data_i;
      if (accept && ps_fire)    print_stat_tag_o <= req_data_i;
      if (accept && pc_fire)    putchar_o <= req_data_i[7:0];
      if (accept && fin_fire)   finish_code_o <= req_data_i;
      if (accept && err && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

  assign finish_o      = (state_r == FINISHED);
  assign head          = resp_v_o ? mem_r[rd_ptr_r] : '0;
  assign resp_type_o   = head.rtype;
  assign resp_data_o   = head.data;
  assign resp_reg_id_o = head.reg_id;
  assign resp_dst_x_o  = head.dst_x;
  assign resp_dst_y_o  = head.dst_y;
endmodule

// File: doc/bsg_manycore_io_responder.md
# bsg_manycore_io_responder

Host-side request responder for the manycore IO link. It accepts request packets that tiles send to the IO coordinate and serves them. Stores update scratch registers or fire host events (print_stat, finish, putchar). Loads return data. Every request gets exactly one response packet, queued through a credit-safe response FIFO back toward the manycore.

## Interface
Parameters:
- addr_width_p, 28: EPA width (word address).
- data_width_p, 32: payload width.
- x_cord_width_p, 7: X coordinate width.
- y_cord_width_p, 7: Y coordinate width.
- resp_els_p, 4: response FIFO depth, minimum 2.

Ports:
- clk_i in 1: single clock.
- reset_n_i in 1: synchronous, active-low reset.
- req_v_i in 1: request valid.
- req_ready_o out 1: request accepted when req_v_i & req_ready_o.
- req_op_i in 2: 0=load, 1=store, 2/3=unsupported.
- req_addr_i in addr_width_p: word EPA.
- req_data_i in data_width_p: store data.
- req_reg_id_i in 5: tag echoed in the response.
- req_src_x_i in x_cord_width_p: requester X coordinate.
- req_src_y_i in y_cord_width_p: requester Y coordinate.
- resp_v_o out 1: response valid.
- resp_ready_i in 1: response consumed when resp_v_o & resp_ready_i.
- resp_type_o out 1: 0=store ack, 1=load data.
- resp_data_o out data_width_p: load data (0 for acks).
- resp_reg_id_o out 5: echoed tag.
- resp_dst_x_o out x_cord_width_p: copy of req_src_x_i.
- resp_dst_y_o out y_cord_width_p: copy of req_src_y_i.
- print_stat_v_o out 1: one-cycle pulse.
- print_stat_tag_o out data_width_p: tag for the print_stat event.
- putchar_v_o out 1: one-cycle pulse.
- putchar_o out 8: character for the putchar event.
- finish_o out 1: sticky finish flag.
- finish_code_o out data_width_p: finish exit code.
- err_cnt_o out 16: count of unsupported requests, saturating.

## Operation
Address map (word address):
- 'h000–'h007: scratch[0..7], read/write.
- 'h100: print_stat, write-only.
- 'h101: finish, write-only.
- 'h102: putchar, write-only; data[7:0] is the character.
- 'h103: cycle counter low word, read-only.
- Everything else is unmapped.

Request handling:
- Store to scratch: the register is written and an ack is returned.
- Store to an event address: the corresponding event fires and an ack is returned.
- Load from scratch: returns the register value.
- Load from 'h103: returns the counter value.
- Load from a write-only address or an unmapped address: returns 32'hDEAD_BEEF, err_cnt +1.
- Store to 'h103 or an unmapped address: dropped, ack returned, err_cnt +1.
- Op 2/3: ack returned, err_cnt +1.
- err_cnt saturates at 'hFFFF.

Finish state machine, RUN → FINISHED:
- A store to 'h101 in RUN sets finish_o=1, latches finish_code_o and moves to FINISHED.
- In FINISHED, requests are still accepted and responded to.
- In FINISHED, event stores (print_stat, finish, putchar) are acked but fire no pulse and update nothing.
- Scratch registers remain writable in FINISHED.
- FINISHED is left only by reset.

Response FIFO:
- req_ready_o = ~full, registered from the occupancy count.
- No enqueue bypass when full: a same-cycle dequeue does not allow an enqueue that cycle.
- Responses leave in request order.
- Response fields hold stable while resp_v_o & ~resp_ready_i.

## Timing
- A request accepted at cycle N:
  - the response is enqueued at the edge ending N;
  - resp_v_o is high at N+1 if the FIFO was empty;
  - event pulses and scratch updates are visible at N+1.
- A load issued at cycle N+1 to a scratch register stored at N returns the new value.
- Throughput is one request per cycle while the FIFO is not full.
- The cycle counter increments every cycle from 0 after reset. It is free-running and wraps.
- Reset (reset_n_i=0 at a rising edge), all outputs:
  - FIFO emptied, resp_v_o=0, req_ready_o=1 from the first cycle after reset;
  - scratch=0, err_cnt_o=0;
  - finish_o=0, finish_code_o=0, state RUN;
  - all pulses 0, print_stat_tag_o=0, putchar_o=0;
  - counter=0;
  - all resp_* fields = 0.
- A reset asserted mid-stream discards queued responses; no response is emitted for them.

## Configuration
- BSG_IO_RESPONDER_CYCLE_CTR_EN defined:
  - the 64-bit counter is instantiated;
  - 'h103 returns its low data_width_p bits.
- Not defined:
  - no counter logic;
  - 'h103 is treated as unmapped: a load returns 32'hDEAD_BEEF and increments err_cnt.

## Test plan
- Store 'h1234 to 'h003 with tag 5, then load 'h003 with tag 6 -> ack (type 0, reg_id 5), then data 'h1234 (type 1, reg_id 6), dst equal to the source coordinates.
- Store 'h41 to 'h102 -> putchar_v_o pulses exactly one cycle with putchar_o='h41; then store 7 to 'h101 -> finish_o=1, finish_code_o=7; a later store to 'h102 -> ack with no pulse.
- Hold resp_ready_i=0 and issue 6 requests with resp_els_p=4 -> req_ready_o drops after 4 accepts; release -> 4 responses in order, then the remaining 2 are accepted.
- Load 'h200, op 3 request, store to 'h103 -> data 'hDEAD_BEEF, acks, err_cnt_o=3.
- 3 responses queued, assert reset_n_i=0 for one cycle -> resp_v_o=0, req_ready_o=1, scratch and finish cleared.
- With the macro defined: load 'h103 at accept cycle 20 after reset -> data 20; without the macro -> 'hDEAD_BEEF.
